// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared constants for the seven-segment scan decoder.
//
// Holds the active-low segment patterns (bit7=a .. bit1=g, bit0=dp), the
// substitute value for undecodable patterns, the blanking digit-select value,
// the dwell FSM state encoding and a small digit-select decode helper.
package ssd_pkg;

  // Segment patterns, active-low, dp off (bit0 = 1)
  localparam logic [7:0] SS_0 = 8'b0000_0011;
  localparam logic [7:0] SS_1 = 8'b1001_1111;
  localparam logic [7:0] SS_2 = 8'b0010_0101;
  localparam logic [7:0] SS_3 = 8'b0000_1101;
  localparam logic [7:0] SS_4 = 8'b1001_1001;
  localparam logic [7:0] SS_5 = 8'b0100_1001;
  localparam logic [7:0] SS_6 = 8'b0100_0001;
  localparam logic [7:0] SS_7 = 8'b0001_1111;
  localparam logic [7:0] SS_8 = 8'b0000_0001;
  localparam logic [7:0] SS_9 = 8'b0000_1001;
  localparam logic [7:0] SS_F = 8'b0111_0001;

  // Digit value reported for a pattern that is not in the table
  localparam logic [3:0] DIG_BAD  = 4'hE;
  // All digit selects inactive: the driver is blanking between digits
  localparam logic [3:0] AN_BLANK = 4'hF;

  typedef enum logic [0:0] {
    WAIT_STABLE = 1'b0,
    HELD        = 1'b1
  } dwell_state_e;

  // Returns {one_hot_low, slot_index}. slot_index is only meaningful when
  // exactly one select line is low.
  function automatic logic [2:0] an_decode(input logic [3:0] an);
    logic [2:0] res;
    case (an)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = {1'b0, 2'd0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode -- combinational seven-segment pattern decoder.
//
// Exact inverse of the driver's encode table: every pattern in ssd_pkg maps
// back to its digit; anything else reports DIG_BAD with valid low.
//
// Ports:
//   seg    in   8  active-low segment pattern (bit7=a .. bit1=g, bit0=dp)
//   valid  out  1  pattern found in the decode table
//   digit  out  4  decoded digit value (DIG_BAD when not valid)
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [7:0] seg,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    digit = DIG_BAD;
    case (seg)
      SS_0:    digit = 4'h0;
      SS_1:    digit = 4'h1;
      SS_2:    digit = 4'h2;
      SS_3:    digit = 4'h3;
      SS_4:    digit = 4'h4;
      SS_5:    digit = 4'h5;
      SS_6:    digit = 4'h6;
      SS_7:    digit = 4'h7;
      SS_8:    digit = 4'h8;
      SS_9:    digit = 4'h9;
      SS_F:    digit = 4'hF;
      default: begin
        valid = 1'b0;
        digit = DIG_BAD;
      end
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder -- receive side of the 4-digit multiplexed seven-segment
// driver. Synchronizes the segment and digit-select buses, waits for each
// digit dwell to settle, decodes the pattern into a staging slot and
// publishes all four digits together once every slot has been captured.
//
// Ports:
//   clk           in   1  system clock
//   rst_n         in   1  asynchronous active-low reset
//   seg_in        in   8  segment bus, active-low (bit7=a .. bit1=g, bit0=dp)
//   an_in         in   4  digit select, active-low (4'b1110 = digit0, rightmost)
//   digit0..3     out  4  published frame digits (digit3 = leftmost)
//   digits_valid  out  1  sticky: at least one full frame published
//   frame_done    out  1  one-cycle pulse coincident with a digit update
//   err_seg       out  1  one-cycle pulse after capturing an unknown pattern
//   err_an        out  1  one-cycle pulse after a stable multi-low select
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic [3:0] an_in,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       digits_valid,
  output logic       frame_done,
  output logic       err_seg,
  output logic       err_an
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

  // Input synchronizers
  logic [3:0]       an_meta_q, an_meta_d;
  logic [3:0]       s_an_q, s_an_d;
  logic [7:0]       seg_meta_q, seg_meta_d;
  logic [7:0]       s_seg_q, s_seg_d;

  // Stability tracking
  logic [11:0]      prev_q, prev_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             changed;

  // Dwell FSM
  dwell_state_e     state_q, state_d;
  logic             qualify;

  // Capture / publish
  logic [3:0][3:0]  stage_q, stage_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic             valid_q, valid_d;
  logic             frame_done_q, frame_done_d;
  logic             err_seg_q, err_seg_d;
  logic             err_an_q, err_an_d;
  logic             publish;

  logic             dec_valid;
  logic [3:0]       dec_digit;
  logic [2:0]       an_info;
  logic             an_onehot;
  logic [1:0]       an_idx;

  ssd_seg_decode u_seg_decode (
    .seg   (s_seg_q),
    .valid (dec_valid),
    .digit (dec_digit)
  );

  assign an_info   = an_decode(s_an_q);
  assign an_onehot = an_info[2];
  assign an_idx    = an_info[1:0];

  // Any change of the synchronized pair restarts the dwell.
  assign changed = ({s_an_q, s_seg_q} != prev_q);

  // Publish in the cycle after the last slot has been seen.
  assign publish = (seen_q == 4'hF);

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_STABLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ----
  // cnt_d is this cycle's count of consecutive matching cycles; reaching
  // CNT_MAX means the pair has been seen STABLE_CYC cycles in a row.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_STABLE: if (cnt_d == CNT_MAX) state_d = HELD;
      HELD:        if (changed)          state_d = WAIT_STABLE;
      default:     state_d = WAIT_STABLE;
    endcase
  end

  // ---- FSM: outputs ----
  // A changed cycle forces cnt_d to 0, so qualify can never fire on the
  // cycle a new pair arrives.
  always_comb begin
    qualify = 1'b0;
    if (state_q == WAIT_STABLE && cnt_d == CNT_MAX) qualify = 1'b1;
  end

  // ---- Datapath next state ----
  always_comb begin
    an_meta_d    = an_in;
    s_an_d       = an_meta_q;
    seg_meta_d   = seg_in;
    s_seg_d      = seg_meta_q;
    prev_d       = {s_an_q, s_seg_q};

    if (changed) begin
      cnt_d = 8'd0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    stage_d      = stage_q;
    seen_d       = seen_q;
    dig_d        = dig_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    err_seg_d    = 1'b0;
    err_an_d     = 1'b0;

    // Publish first so a capture in the same cycle starts the next frame.
    if (publish) begin
      dig_d        = stage_q;
      valid_d      = 1'b1;
      frame_done_d = 1'b1;
      seen_d       = 4'h0;
    end

    if (qualify) begin
      if (an_onehot) begin
        stage_d[an_idx] = dec_digit;
        seen_d[an_idx]  = 1'b1;
        err_seg_d       = ~dec_valid;
      end else if (s_an_q != AN_BLANK) begin
        err_an_d = 1'b1;
      end
    end
  end

  // ---- Datapath registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_meta_q    <= AN_BLANK;
      s_an_q       <= AN_BLANK;
      seg_meta_q   <= 8'hFF;
      s_seg_q      <= 8'hFF;
      prev_q       <= {AN_BLANK, 8'hFF};
      cnt_q        <= 8'd0;
      stage_q      <= '0;
      seen_q       <= 4'h0;
      dig_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_seg_q    <= 1'b0;
      err_an_q     <= 1'b0;
    end else begin
      an_meta_q    <= an_meta_d;
      s_an_q       <= s_an_d;
      seg_meta_q   <= seg_meta_d;
      s_seg_q      <= s_seg_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      seen_q       <= seen_d;
      dig_q        <= dig_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      err_seg_q    <= err_seg_d;
      err_an_q     <= err_an_d;
    end
  end

  assign digit0       = dig_q[0];
  assign digit1       = dig_q[1];
  assign digit2       = dig_q[2];
  assign digit3       = dig_q[3];
  assign digits_valid = valid_q;
  assign frame_done   = frame_done_q;
  assign err_seg      = err_seg_q;
  assign err_an       = err_an_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Testbench for ssd_scan_decoder: dwell-level reference model feeding a
// scoreboard queue of expected frames; a monitor pops on frame_done.
module tb_ssd_scan_decoder;

  localparam int STABLE_CYC = 4;
  // A pair visible for at least this many cycles at the pins is captured.
  localparam int THR = STABLE_CYC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_in;
  logic [3:0] an_in;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       digits_valid, frame_done, err_seg, err_an;

  always #5 clk = ~clk;

  ssd_scan_decoder #(.STABLE_CYC(STABLE_CYC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .digit0       (digit0),
    .digit1       (digit1),
    .digit2       (digit2),
    .digit3       (digit3),
    .digits_valid (digits_valid),
    .frame_done   (frame_done),
    .err_seg      (err_seg),
    .err_an       (err_an)
  );

  // Decode table, written out independently of the design package.
  logic [7:0] tbl     [11] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                               8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                               8'b00000001, 8'b00001001, 8'b01110001};
  logic [3:0] tbl_val [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'hF};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_fd_cyc = 0;
  int exp_err_seg = 0, exp_err_an = 0, obs_err_seg = 0, obs_err_an = 0;

  logic [3:0]  m_stage [4];
  logic [3:0]  m_seen;
  logic [3:0]  prev_an;
  logic [7:0]  prev_seg;
  int          run_len;
  logic [15:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [7:0] s);
    for (int i = 0; i < 11; i++)
      if (tbl[i] == s) return {1'b1, tbl_val[i]};
    return {1'b0, 4'hE};
  endfunction

  function automatic int zeros(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) n++;
    return n;
  endfunction

  // Effect of one settled dwell on the model.
  task automatic model_qualify(input logic [3:0] a, input logic [7:0] s);
    logic [4:0] d;
    int slot;
    if (zeros(a) == 1) begin
      slot = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) slot = i;
      d = ref_decode(s);
      m_stage[slot] = d[3:0];
      if (!d[4]) exp_err_seg++;
      m_seen[slot] = 1'b1;
      if (m_seen == 4'hF) begin
        exp_q.push_back({m_stage[3], m_stage[2], m_stage[1], m_stage[0]});
        m_seen = 4'h0;
      end
    end else if (zeros(a) >= 2) begin
      exp_err_an++;
    end
  endtask

  // Drive a pair for len cycles; called #1 after a rising edge.
  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int len);
    int old;
    an_in  = a;
    seg_in = s;
    old = (a == prev_an && s == prev_seg) ? run_len : 0;
    run_len = old + len;
    if (old < THR && run_len >= THR) model_qualify(a, s);
    prev_an  = a;
    prev_seg = s;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      an_in  = 4'($urandom);
      seg_in = 8'($urandom);
      @(posedge clk); #1;
      check("reset_digits", {digit3, digit2, digit1, digit0}, 16'h0);
      check("reset_flags", {digits_valid, frame_done, err_seg, err_an}, 4'h0);
    end
    an_in  = 4'hF;
    seg_in = 8'hFF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_stage[i] = 4'h0;
    m_seen   = 4'h0;
    prev_an  = 4'hF;
    prev_seg = 8'hFF;
    run_len  = 1000;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
    check("pending_frames", exp_q.size(), 0);
    check("err_seg_count", obs_err_seg, exp_err_seg);
    check("err_an_count", obs_err_an, exp_err_an);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_done) begin
        last_fd_cyc = cyc;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got digits %0h, expected no frame",
                   {digit3, digit2, digit1, digit0});
        end else begin
          check("frame_digits", {digit3, digit2, digit1, digit0}, exp_q.pop_front());
          check("frame_valid", digits_valid, 1'b1);
        end
      end
      if (err_seg) obs_err_seg++;
      if (err_an)  obs_err_an++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [3:0] a;
    logic [7:0] s;
    int len;
    rst_n  = 1'b0;
    an_in  = 4'hF;
    seg_in = 8'hFF;
    do_reset(4);
    check("valid_after_reset", digits_valid, 1'b0);

    // Clean scan: frame 1,2,3,4 seven cycles after the fourth dwell starts
    dwell(4'b1110, 8'b10011001, 16);
    dwell(4'b1101, 8'b00001101, 16);
    dwell(4'b1011, 8'b00100101, 16);
    c0 = cyc;
    dwell(4'b0111, 8'b10011111, 16);
    check("clean_latency", last_fd_cyc - c0, 7);
    check("clean_valid", digits_valid, 1'b1);
    check("clean_digits", {digit3, digit2, digit1, digit0}, 16'h1234);
    settle(4);

    // Glitch rejection on digit1
    dwell(4'b1110, 8'b00011111, 10);
    dwell(4'b1101, 8'b01001001, 8);
    dwell(4'b1101, 8'b00000001, 2);
    dwell(4'b1101, 8'b01001001, 10);
    dwell(4'b1011, 8'b01000001, 10);
    dwell(4'b0111, 8'b00001001, 10);
    settle(6);

    // Invalid pattern on digit2, F on digit0
    dwell(4'b1011, 8'hFF, 10);
    dwell(4'b1110, 8'b01110001, 10);
    dwell(4'b1101, 8'b00000011, 10);
    dwell(4'b0111, 8'b00000001, 10);
    settle(6);

    // Bad select then blanking
    dwell(4'b1100, 8'b00001101, 10);
    dwell(4'b1111, 8'b00001101, 10);
    settle(4);

    // Reset mid-frame
    dwell(4'b1110, 8'b10011111, 10);
    dwell(4'b1101, 8'b00100101, 10);
    do_reset(3);
    check("midreset_valid", digits_valid, 1'b0);
    dwell(4'b1011, 8'b00001101, 10);
    dwell(4'b0111, 8'b10011001, 10);
    settle(10);
    check("partial_valid", digits_valid, 1'b0);
    dwell(4'b1110, 8'b01001001, 10);
    dwell(4'b1101, 8'b01000001, 10);
    settle(8);
    check("rescan_valid", digits_valid, 1'b1);

    // Randomized dwells
    for (int it = 0; it < 80; it++) begin
      do begin
        case ($urandom_range(0, 9))
          0: a = 4'hF;
          1: begin
            do a = 4'($urandom_range(0, 15)); while (zeros(a) < 2);
          end
          default: a = ~(4'b0001 << $urandom_range(0, 3));
        endcase
        if ($urandom_range(0, 4) == 0) s = 8'($urandom);
        else s = tbl[$urandom_range(0, 10)];
      end while (a == prev_an && s == prev_seg);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(8, 20);
      dwell(a, s, len);
    end
    settle(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
